dds_serial_port: RTL and testbench

//  Serial-port engine for the AD9910-class DDS, downstream of the sequencing controller. Accepts one

---
 rtl/dds_serial_port_pkg.sv | 36 +++
 rtl/dds_serial_port_if.sv | 19 +
 rtl/dds_serial_port_sclk_gen.sv | 42 ++++
 rtl/dds_serial_port.sv | 186 ++++++++++++++++++
 tb/tb_dds_serial_port.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/dds_serial_port_pkg.sv
// dds_pkg: shared types and helpers for the DDS serial-port engine.
//   dds_state_e : command FSM states
//   REG_POW     : address of the only 2-byte register (POW)
//   reg_bytes() : data-phase length in bytes for a register address
//   tx_frame()  : 40-bit MSB-first shift image of a command
package dds_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_CS_SU,
        ST_SHIFT,
        ST_CS_HD,
        ST_IOUP_WT,
        ST_IOUP,
        ST_DONE
    } dds_state_e;

    localparam logic [4:0] REG_POW = 5'h08;

    function automatic logic [2:0] reg_bytes(input logic [4:0] addr);
        return (addr == REG_POW) ? 3'd2 : 3'd4;
    endfunction

    // Instruction byte followed by the data word, left-aligned so bit 39 goes
    // out first. Reads shift zeros during the data phase. 2-byte frames only
    // use the top 24 bits.
    function automatic logic [39:0] tx_frame(input logic [7:0] order, input logic [31:0] wdata);
        logic [31:0] d;
        d = order[7] ? 32'h0 : wdata;
        if (reg_bytes(order[4:0]) == 3'd2)
            return {order, d[15:0], 16'h0};
        return {order, d};
    endfunction

endpackage

// File: rtl/dds_serial_port_if.sv
// dds_serial_port_if: command handshake between the sequencing controller
// (master) and the serial-port engine (slave).
//   start  : command request level, rising edge accepted when idle
//   order  : instruction byte ([7]=read, [4:0]=address)
//   wdata  : write data, right-justified
//   rdata  : read result, right-justified, zero-extended
//   done   : one-cycle completion pulse
//   busy   : engine occupied
interface dds_serial_port_if;
    logic        start;
    logic [7:0]  order;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        busy;

    modport master (output start, order, wdata, input rdata, done, busy);
    modport slave  (input start, order, wdata, output rdata, done, busy);
endinterface

// File: rtl/dds_serial_port_sclk_gen.sv
// dds_sclk_gen: SCLK timing strobes for the serial shifter.
//   clk, rst_n : system clock, async active-low reset
//   en         : run the divider; low holds it at the start of a low half
//   sclk_rise  : this clk edge starts an SCLK high half
//   sclk_fall  : this clk edge starts an SCLK low half
// Each half period is CLK_DIV clk cycles; the first half after enable is low.
module dds_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] div_cnt;
    logic        phase;   // 0: in low half, 1: in high half
    logic        wrap;

    assign wrap      = (div_cnt == DIV_LAST);
    assign sclk_rise = en & wrap & ~phase;
    assign sclk_fall = en & wrap & phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/dds_serial_port.sv
// dds_serial_port: serial-port engine for an AD9910-class DDS.
// Takes one register command from the controller, frames it with CS, shifts
// instruction + data MSB-first on SCLK/SDIO, captures SDO on reads and pulses
// IO_UPDATE after writes (optionally aligned to SYNC_CLK).
//   clk, rst_n : system clock, async active-low reset
//   cmd        : command handshake (slave side)
//   SDO        : DDS serial data out (4-wire mode)
//   SYNC_CLK   : DDS SYNC_CLK, asynchronous to clk
//   SCLK, SDIO, CS, IO_UPDATE, SYNCIO : DDS serial pins, all registered
module dds_serial_port
    import dds_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int IOUP_W    = 4,
    parameter int SYNCIO_W  = 4,
    parameter int IOUP_SYNC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dds_serial_port_if.slave    cmd,
    input  logic                SDO,
    input  logic                SYNC_CLK,
    output logic                SCLK,
    output logic                SDIO,
    output logic                CS,
    output logic                IO_UPDATE,
    output logic                SYNCIO
);

    localparam logic [15:0] CS_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] IOUP_LAST = 16'(IOUP_W - 1);
    localparam logic [15:0] SYNC_LAST = 16'(SYNCIO_W - 1);

    dds_state_e  state;
    logic [15:0] cnt;        // phase timer for SYNC / CS_SU / CS_HD / IOUP
    logic [5:0]  bit_cnt;    // bits left after the current one
    logic [39:0] tx_sh;
    logic        is_read;
    logic [2:0]  nbytes;
    logic        start_q;
    logic [2:0]  sync_ff;    // [1:0] synchroniser, [2] edge-detect history
    logic [31:0] rdata_q;
    logic        done_q;
    logic        busy_q;

    logic        accept;
    logic        sync_rise;
    logic        sclk_rise;
    logic        sclk_fall;
    logic [2:0]  acc_bytes;

    assign accept    = cmd.start & ~start_q;
    assign sync_rise = sync_ff[1] & ~sync_ff[2];
    assign acc_bytes = reg_bytes(cmd.order[4:0]);

    assign cmd.rdata = rdata_q;
    assign cmd.done  = done_q;
    assign cmd.busy  = busy_q;

    dds_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == ST_SHIFT),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SYNC;
            cnt       <= SYNC_LAST;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            is_read   <= 1'b0;
            nbytes    <= 3'd4;
            start_q   <= 1'b0;
            sync_ff   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            SCLK      <= 1'b0;
            SDIO      <= 1'b0;
            CS        <= 1'b1;
            IO_UPDATE <= 1'b0;
            SYNCIO    <= 1'b1;
        end else begin
            // Edge detector runs everywhere so an edge seen while busy is
            // consumed, not replayed once the engine goes idle.
            start_q <= cmd.start;
            sync_ff <= {sync_ff[1:0], SYNC_CLK};
            done_q  <= 1'b0;

            case (state)
                ST_SYNC: begin
                    if (cnt == '0) begin
                        SYNCIO <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (accept) begin
                        is_read <= cmd.order[7];
                        nbytes  <= acc_bytes;
                        tx_sh   <= tx_frame(cmd.order, cmd.wdata);
                        bit_cnt <= (acc_bytes == 3'd2) ? 6'd23 : 6'd39;
                        if (cmd.order[7])
                            rdata_q <= '0;
                        busy_q  <= 1'b1;
                        CS      <= 1'b0;
                        SDIO    <= cmd.order[7];
                        cnt     <= CS_LAST;
                        state   <= ST_CS_SU;
                    end
                end

                ST_CS_SU: begin
                    if (cnt == '0)
                        state <= ST_SHIFT;
                    else
                        cnt <= cnt - 16'd1;
                end

                ST_SHIFT: begin
                    if (sclk_rise) begin
                        SCLK <= 1'b1;
                        // Only data-phase bits land in rdata, keeping it right-justified.
                        if (is_read && (bit_cnt < {nbytes, 3'b000}))
                            rdata_q <= {rdata_q[30:0], SDO};
                    end
                    if (sclk_fall) begin
                        SCLK <= 1'b0;
                        if (bit_cnt == '0) begin
                            SDIO  <= 1'b0;
                            cnt   <= CS_LAST;
                            state <= ST_CS_HD;
                        end else begin
                            bit_cnt <= bit_cnt - 6'd1;
                            tx_sh   <= {tx_sh[38:0], 1'b0};
                            SDIO    <= tx_sh[38];
                        end
                    end
                end

                ST_CS_HD: begin
                    if (cnt == '0) begin
                        CS    <= 1'b1;
                        state <= is_read ? ST_DONE : ST_IOUP_WT;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_IOUP_WT: begin
                    if ((IOUP_SYNC == 0) || sync_rise) begin
                        IO_UPDATE <= 1'b1;
                        cnt       <= IOUP_LAST;
                        state     <= ST_IOUP;
                    end
                end

                ST_IOUP: begin
                    if (cnt == '0) begin
                        IO_UPDATE <= 1'b0;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end

                ST_DONE: begin
                    // busy stays up through the done cycle and drops in IDLE.
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dds_serial_port.sv
// tb_dds_serial_port: directed bench for dds_serial_port.
// u0 runs with immediate IO_UPDATE (IOUP_SYNC=0), u1 with SYNC_CLK alignment.
module tb_dds_serial_port;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_clk = 1'b0;

    always #5 clk = ~clk;
    initial begin
        #3;
        forever #20 sync_clk = ~sync_clk;
    end

    dds_serial_port_if if0 ();
    dds_serial_port_if if1 ();

    logic sclk0, sdio0, cs0, iou0, syncio0, sdo0;
    logic sclk1, sdio1, cs1, iou1, syncio1;

    dds_serial_port #(.CLK_DIV(2), .IOUP_W(4), .SYNCIO_W(4), .IOUP_SYNC(0)) u0 (
        .clk(clk), .rst_n(rst_n), .cmd(if0), .SDO(sdo0), .SYNC_CLK(sync_clk),
        .SCLK(sclk0), .SDIO(sdio0), .CS(cs0), .IO_UPDATE(iou0), .SYNCIO(syncio0)
    );

    dds_serial_port #(.CLK_DIV(2), .IOUP_W(4), .SYNCIO_W(4), .IOUP_SYNC(1)) u1 (
        .clk(clk), .rst_n(rst_n), .cmd(if1), .SDO(1'b0), .SYNC_CLK(sync_clk),
        .SCLK(sclk1), .SDIO(sdio1), .CS(cs1), .IO_UPDATE(iou1), .SYNCIO(syncio1)
    );

    int total = 0;
    int bad = 0;

    // Monitors on u0 pins.
    logic [63:0] rx_sh = '0;
    int rises = 0;
    int fall_cnt = 0;
    int cs_base = 0;
    int iou_pulses = 0;
    int iou_cyc = 0;
    int done_cnt = 0;
    logic [31:0] sdo_word = 32'h0;

    always @(posedge sclk0) begin
        rx_sh = {rx_sh[62:0], sdio0};
        rises++;
    end
    always @(negedge sclk0) fall_cnt++;
    always @(negedge cs0) cs_base = fall_cnt;
    always @(posedge iou0) iou_pulses++;
    always @(posedge clk) begin
        if (iou0) iou_cyc++;
        if (if0.done) done_cnt++;
    end

    // SDO model: DDS presents data bit k after the (8+k)-th SCLK fall of the frame.
    int sdo_n;
    always_comb begin
        sdo_n = fall_cnt - cs_base;
        sdo0 = 1'b0;
        if (sdo_n >= 8 && sdo_n < 40)
            sdo0 = sdo_word[39 - sdo_n];
    end

    // u1 IO_UPDATE alignment monitor.
    longint t_sync = 0;
    longint iou1_delay = -1;
    int iou1_pulses = 0;
    always @(posedge sync_clk) t_sync = $time;
    always @(posedge iou1) begin
        iou1_delay = $time - t_sync;
        iou1_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a command on u0 from a negedge; returns the number of clk edges
    // from the accepting edge to the first negedge with done high.
    task automatic run_cmd(input logic [7:0] o, input logic [31:0] w, output int lat);
        if0.order = o;
        if0.wdata = w;
        if0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if0.start = 1'b0;
        lat = 0;
        while (lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (if0.done === 1'b1) break;
        end
    endtask

    initial begin
        int lat, r0, p0, c0, d0;
        if0.start = 1'b0; if0.order = '0; if0.wdata = '0;
        if1.start = 1'b0; if1.order = '0; if1.wdata = '0;

        // Reset state
        repeat (10) @(negedge clk);
        chk("rst_cs", cs0, 1'b1);
        chk("rst_syncio", syncio0, 1'b1);
        chk("rst_busy", if0.busy, 1'b1);
        chk("rst_sclk", sclk0, 1'b0);
        chk("rst_ioup", iou0, 1'b0);
        chk("rst_done", if0.done, 1'b0);
        chk("rst_rdata", if0.rdata, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("sync_hi", syncio0, 1'b1);
        chk("sync_busy", if0.busy, 1'b1);
        @(negedge clk);
        chk("sync_lo", syncio0, 1'b0);
        chk("sync_idle", if0.busy, 1'b0);
        repeat (3) @(negedge clk);

        // Write 4-byte register
        r0 = rises; p0 = iou_pulses; c0 = iou_cyc;
        run_cmd(8'h07, 32'h1234_5678, lat);
        chk("w07_lat", lat, 170);
        chk("w07_busy_done", if0.busy, 1'b1);
        chk("w07_rises", rises - r0, 40);
        chk("w07_stream", rx_sh[39:0], 40'h07_1234_5678);
        chk("w07_ioup_n", iou_pulses - p0, 1);
        chk("w07_ioup_w", iou_cyc - c0, 4);
        chk("w07_cs", cs0, 1'b1);
        @(negedge clk);
        chk("w07_busy_after", if0.busy, 1'b0);
        chk("w07_done_after", if0.done, 1'b0);
        repeat (3) @(negedge clk);

        // Read 4-byte register
        sdo_word = 32'hDEAD_BEEF;
        r0 = rises; p0 = iou_pulses;
        run_cmd(8'h87, 32'h5555_5555, lat);
        chk("r87_lat", lat, 165);
        chk("r87_rdata", if0.rdata, 32'hDEAD_BEEF);
        chk("r87_rises", rises - r0, 40);
        chk("r87_stream", rx_sh[39:0], 40'h87_0000_0000);
        chk("r87_no_ioup", iou_pulses - p0, 0);
        repeat (3) @(negedge clk);

        // Write 2-byte POW register; rdata must survive
        r0 = rises; p0 = iou_pulses;
        run_cmd(8'h08, 32'hFFFF_ABCD, lat);
        chk("w08_lat", lat, 106);
        chk("w08_rises", rises - r0, 24);
        chk("w08_stream", rx_sh[23:0], 24'h08_ABCD);
        chk("w08_ioup_n", iou_pulses - p0, 1);
        chk("w08_rdata_kept", if0.rdata, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);

        // start held high for 300 cycles -> one command only
        d0 = done_cnt; p0 = iou_pulses;
        if0.order = 8'h07; if0.wdata = 32'hA5A5_0F0F;
        if0.start = 1'b1;
        repeat (300) @(negedge clk);
        if0.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_done_n", done_cnt - d0, 1);
        chk("hold_ioup_n", iou_pulses - p0, 1);

        // start toggled while busy -> ignored
        d0 = done_cnt;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            if0.start = ~if0.start;
            repeat (7) @(negedge clk);
        end
        repeat (200) @(negedge clk);
        chk("toggle_done_n", done_cnt - d0, 1);
        chk("toggle_idle", if0.busy, 1'b0);

        // Reset asserted mid-SHIFT
        if0.order = 8'h07; if0.wdata = 32'hFFFF_FFFF;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_cs_low", cs0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", cs0, 1'b1);
        chk("mid_rst_sclk", sclk0, 1'b0);
        chk("mid_rst_syncio", syncio0, 1'b1);
        chk("mid_rst_busy", if0.busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_recover", if0.busy, 1'b0);

        // u1: IO_UPDATE aligned to synchronised SYNC_CLK rise
        if1.order = 8'h07; if1.wdata = 32'h0000_0001;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        lat = 0;
        while (lat < 2000 && if1.done !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        chk("u1_done_seen", if1.done, 1'b1);
        chk("u1_ioup_n", iou1_pulses, 1);
        chk("u1_ioup_align", (iou1_delay >= 20 && iou1_delay <= 40), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
